// File: rtl/l2_trace_pkg.sv
// rtl/l2_trace_pkg.sv - shared types and command codes for the trace command dispatcher
//
// Purpose: L2 request opcodes, trace command code constants, dispatcher FSM
//          states and a small command-classification helper.
// Ports:   none (package).

package l2_trace_pkg;

  typedef enum logic [2:0] {
    OP_DR = 3'd0,
    OP_DW = 3'd1,
    OP_IR = 3'd2,
    OP_SI = 3'd3,
    OP_SR = 3'd4,
    OP_SW = 3'd5,
    OP_SM = 3'd6
  } l2_op_e;

  localparam logic [3:0] CMD_DR    = 4'd0;
  localparam logic [3:0] CMD_DW    = 4'd1;
  localparam logic [3:0] CMD_IR    = 4'd2;
  localparam logic [3:0] CMD_SI    = 4'd3;
  localparam logic [3:0] CMD_SR    = 4'd4;
  localparam logic [3:0] CMD_SW    = 4'd5;
  localparam logic [3:0] CMD_SM    = 4'd6;
  localparam logic [3:0] CMD_CLEAR = 4'd8;
  localparam logic [3:0] CMD_PRINT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_PRINT_WAIT = 2'd2
  } dispatch_state_e;

  // Codes 0..6 map one-to-one onto l2_op_e.
  function automatic logic is_req_cmd(input logic [3:0] cmd);
    return (cmd <= CMD_SM);
  endfunction

endpackage

// File: rtl/trace_cmd_fifo.sv
// rtl/trace_cmd_fifo.sv - synchronous FIFO buffering parsed trace records
//
// Purpose: DEPTH-entry FIFO with an extra pointer bit so full/empty are
//          distinguished without a separate counter register.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pointers only)
//   i_push        write i_push_data (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   i_push_data   record to store
//   o_full        DEPTH entries held
//   o_empty       no entries held
//   o_head        oldest entry (valid when !o_empty)
//   o_count       number of entries held

module trace_cmd_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_push_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_head,
  output logic [AW:0]   o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // Same slot, opposite lap bit: writer is a full lap ahead.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trace_cmd_dispatch.sv
// rtl/trace_cmd_dispatch.sv - decodes buffered trace records into L2 requests, clear and print
//
// Purpose: buffers trace records in trace_cmd_fifo and dispatches them in
//          order: codes 0-6 become L2 requests (address split into
//          tag/index/offset), 8 a one-cycle clear pulse, 9 a print
//          request/done handshake, anything else is dropped and flagged.
//          Optional statistics counters are built when the macro
//          TRACE_DISPATCH_STATS_EN is defined.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          trace record handshake; in_ready = !full
//   in_cmd, in_addr            trace command code and address
//   req_valid/req_ready        L2 request handshake
//   req_op/tag/index/offset    L2 request payload
//   clear_pulse                one-cycle cache clear
//   print_req/print_done       cache dump handshake
//   err_illegal                one-cycle pulse per dropped record
//   busy                       FIFO non-empty or FSM not idle
//   stat_*                     saturating counters (TRACE_DISPATCH_STATS_EN only)

module trace_cmd_dispatch
  import l2_trace_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     in_cmd,
  input  logic [ADDR_W-1:0]              in_addr,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [2:0]                     req_op,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] req_tag,
  output logic [INDEX_W-1:0]             req_index,
  output logic [OFFSET_W-1:0]            req_offset,
  output logic                           clear_pulse,
  output logic                           print_req,
  input  logic                           print_done,
  output logic                           err_illegal,
  output logic                           busy
`ifdef TRACE_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]               stat_reads,
  output logic [CNT_W-1:0]               stat_writes,
  output logic [CNT_W-1:0]               stat_fetches,
  output logic [CNT_W-1:0]               stat_snoops,
  output logic [CNT_W-1:0]               stat_illegal
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int REC_W = 4 + ADDR_W;
  localparam int AW    = $clog2(DEPTH);

  logic              w_full;
  logic              w_empty;
  logic [REC_W-1:0]  w_head;
  logic [AW:0]       w_count;
  logic [AW:0]       w_cnt_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_ne_nxt;
  logic [3:0]        w_head_cmd;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_req;
  logic              w_head_clear;
  logic              w_head_print;

  dispatch_state_e   r_state;
  logic              r_req_valid;
  l2_op_e            r_req_op;
  logic [TAG_W-1:0]  r_req_tag;
  logic [INDEX_W-1:0]  r_req_index;
  logic [OFFSET_W-1:0] r_req_offset;
  logic              r_clear;
  logic              r_print;
  logic              r_err;
  logic              r_busy;

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  trace_cmd_fifo #(
    .DW    (REC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data ({in_cmd, in_addr}),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign w_head_cmd   = w_head[REC_W-1 -: 4];
  assign w_head_addr  = w_head[ADDR_W-1:0];
  assign w_head_req   = is_req_cmd(w_head_cmd);
  assign w_head_clear = (w_head_cmd == CMD_CLEAR);
  assign w_head_print = (w_head_cmd == CMD_PRINT);

  // IDLE consumes any head record; ISSUE only chains the next request
  // on a handshake, so non-request codes wait until after it.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE:  w_pop = !w_empty;
      ST_ISSUE: w_pop = req_ready && !w_empty && w_head_req;
      default:  w_pop = 1'b0;
    endcase
  end

  // busy is registered, so it is computed from next-cycle occupancy.
  assign w_cnt_nxt     = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign w_fifo_ne_nxt = (w_cnt_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req_valid  <= 1'b0;
      r_req_op     <= OP_DR;
      r_req_tag    <= '0;
      r_req_index  <= '0;
      r_req_offset <= '0;
      r_clear      <= 1'b0;
      r_print      <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_head_req) begin
              r_req_op     <= l2_op_e'(w_head_cmd[2:0]);
              r_req_tag    <= w_head_addr[ADDR_W-1 -: TAG_W];
              r_req_index  <= w_head_addr[OFFSET_W +: INDEX_W];
              r_req_offset <= w_head_addr[OFFSET_W-1:0];
              r_req_valid  <= 1'b1;
              r_state      <= ST_ISSUE;
              r_busy       <= 1'b1;
            end else if (w_head_clear) begin
              r_clear <= 1'b1;
              r_busy  <= w_fifo_ne_nxt;
            end else if (w_head_print) begin
              r_print <= 1'b1;
              r_state <= ST_PRINT_WAIT;
              r_busy  <= 1'b1;
            end else begin
              r_err  <= 1'b1;
              r_busy <= w_fifo_ne_nxt;
            end
          end else begin
            r_busy <= w_fifo_ne_nxt;
          end
        end
        ST_ISSUE: begin
          if (req_ready) begin
            if (w_pop) begin
              r_req_op     <= l2_op_e'(w_head_cmd[2:0]);
              r_req_tag    <= w_head_addr[ADDR_W-1 -: TAG_W];
              r_req_index  <= w_head_addr[OFFSET_W +: INDEX_W];
              r_req_offset <= w_head_addr[OFFSET_W-1:0];
              r_busy       <= 1'b1;
            end else begin
              r_req_valid <= 1'b0;
              r_state     <= ST_IDLE;
              r_busy      <= w_fifo_ne_nxt;
            end
          end else begin
            r_busy <= 1'b1;
          end
        end
        ST_PRINT_WAIT: begin
          if (print_done) begin
            r_print <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= w_fifo_ne_nxt;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_valid <= 1'b0;
          r_print     <= 1'b0;
          r_busy      <= w_fifo_ne_nxt;
        end
      endcase
    end
  end

  assign req_valid   = r_req_valid;
  assign req_op      = r_req_op;
  assign req_tag     = r_req_tag;
  assign req_index   = r_req_index;
  assign req_offset  = r_req_offset;
  assign clear_pulse = r_clear;
  assign print_req   = r_print;
  assign err_illegal = r_err;
  assign busy        = r_busy;

`ifdef TRACE_DISPATCH_STATS_EN
  logic [CNT_W-1:0] r_stat_reads;
  logic [CNT_W-1:0] r_stat_writes;
  logic [CNT_W-1:0] r_stat_fetches;
  logic [CNT_W-1:0] r_stat_snoops;
  logic [CNT_W-1:0] r_stat_illegal;
  logic             w_hs;
  logic             w_drop;

  assign w_hs   = r_req_valid && req_ready;
  assign w_drop = (r_state == ST_IDLE) && !w_empty && !w_head_req &&
                  !w_head_clear && !w_head_print;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_reads   <= '0;
      r_stat_writes  <= '0;
      r_stat_fetches <= '0;
      r_stat_snoops  <= '0;
      r_stat_illegal <= '0;
    end else begin
      if (w_hs) begin
        case (r_req_op)
          OP_DR:   if (r_stat_reads   != '1) r_stat_reads   <= r_stat_reads   + 1'b1;
          OP_DW:   if (r_stat_writes  != '1) r_stat_writes  <= r_stat_writes  + 1'b1;
          OP_IR:   if (r_stat_fetches != '1) r_stat_fetches <= r_stat_fetches + 1'b1;
          default: if (r_stat_snoops  != '1) r_stat_snoops  <= r_stat_snoops  + 1'b1;
        endcase
      end
      if (w_drop && (r_stat_illegal != '1)) begin
        r_stat_illegal <= r_stat_illegal + 1'b1;
      end
    end
  end

  assign stat_reads   = r_stat_reads;
  assign stat_writes  = r_stat_writes;
  assign stat_fetches = r_stat_fetches;
  assign stat_snoops  = r_stat_snoops;
  assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// tb/tb_trace_cmd_dispatch.sv - self-checking bench for trace_cmd_dispatch

module tb_trace_cmd_dispatch;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] tag;
    logic [13:0] idx;
    logic [5:0]  off;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = 4'd0;
  logic [31:0] in_addr = 32'd0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [2:0]  req_op;
  logic [11:0] req_tag;
  logic [13:0] req_index;
  logic [5:0]  req_offset;
  logic        clear_pulse;
  logic        print_req;
  logic        print_done = 1'b0;
  logic        err_illegal;
  logic        busy;
`ifdef TRACE_DISPATCH_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_fetches, stat_snoops, stat_illegal;
`endif

  trace_cmd_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_addr     (in_addr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .req_index   (req_index),
    .req_offset  (req_offset),
    .clear_pulse (clear_pulse),
    .print_req   (print_req),
    .print_done  (print_done),
    .err_illegal (err_illegal),
    .busy        (busy)
`ifdef TRACE_DISPATCH_STATS_EN
    ,
    .stat_reads   (stat_reads),
    .stat_writes  (stat_writes),
    .stat_fetches (stat_fetches),
    .stat_snoops  (stat_snoops),
    .stat_illegal (stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_hs = 0;
  int   n_clear = 0;
  int   n_err = 0;
  int   m_reads = 0, m_writes = 0, m_fetches = 0, m_snoops = 0, m_illegal = 0;
  exp_t exp_q[$];
  int   hs_cyc[$];
  exp_t mon_e;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t split(input logic [3:0] c, input logic [31:0] a);
    exp_t r;
    r.op  = c[2:0];
    r.tag = 12'(a >> 20);
    r.idx = 14'((a >> 6) & 32'h3FFF);
    r.off = 6'(a & 32'h3F);
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: requests are popped and compared where the handshake is
  // about to happen on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_pulse) n_clear++;
      if (err_illegal) n_err++;
      if (req_valid && req_ready) begin
        n_hs++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got op=%0d, required no request", req_op);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_op", 64'(req_op), 64'(mon_e.op));
          chk("sb_tag", 64'(req_tag), 64'(mon_e.tag));
          chk("sb_index", 64'(req_index), 64'(mon_e.idx));
          chk("sb_offset", 64'(req_offset), 64'(mon_e.off));
          case (mon_e.op)
            3'd0: m_reads++;
            3'd1: m_writes++;
            3'd2: m_fetches++;
            default: m_snoops++;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_cmd   = c;
    in_addr  = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      if (c <= 4'd6) exp_q.push_back(split(c, a));
      if (c == 4'd7 || c >= 4'd10) m_illegal++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_q_empty();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_stats();
`ifdef TRACE_DISPATCH_STATS_EN
    chk("stat_reads", 64'(stat_reads), 64'(m_reads));
    chk("stat_writes", 64'(stat_writes), 64'(m_writes));
    chk("stat_fetches", 64'(stat_fetches), 64'(m_fetches));
    chk("stat_snoops", 64'(stat_snoops), 64'(m_snoops));
    chk("stat_illegal", 64'(stat_illegal), 64'(m_illegal));
`endif
  endtask

  initial begin
    vecs[0] = '{4'd0, 32'h1234_5678, '{3'd0, 12'h123, 14'h1159, 6'h38}};
    vecs[1] = '{4'd1, 32'hFFFF_FFFF, '{3'd1, 12'hFFF, 14'h3FFF, 6'h3F}};
    vecs[2] = '{4'd2, 32'h0000_0000, '{3'd2, 12'h000, 14'h0000, 6'h00}};
    vecs[3] = '{4'd3, 32'h0000_0040, '{3'd3, 12'h000, 14'h0001, 6'h00}};
    vecs[4] = '{4'd4, 32'h0010_0000, '{3'd4, 12'h001, 14'h0000, 6'h00}};
    vecs[5] = '{4'd5, 32'h0000_003F, '{3'd5, 12'h000, 14'h0000, 6'h3F}};
    vecs[6] = '{4'd6, 32'h800F_FFC0, '{3'd6, 12'h800, 14'h3FFF, 6'h00}};
    vecs[7] = '{4'd0, 32'hA5A5_A5A5, '{3'd0, 12'hA5A, 14'h1696, 6'h25}};

    // Reset with in_valid held high.
    #2 rst_n = 1'b0;
    in_valid = 1'b1;
    in_cmd   = 4'd0;
    in_addr  = 32'h1234_5678;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_clear", 64'(clear_pulse), 64'd0);
    chk("rst_print", 64'(print_req), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_payload", 64'({req_op, req_tag, req_index, req_offset}), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk_stats();

    // Table: each record alone, first-transaction latency and address split.
    foreach (vecs[i]) begin
      req_ready = 1'b0;
      send(vecs[i].cmd, vecs[i].addr);
      chk("tbl_not_yet", 64'(req_valid), 64'd0);
      tick();
      chk("tbl_valid", 64'(req_valid), 64'd1);
      chk("tbl_op", 64'(req_op), 64'(vecs[i].e.op));
      chk("tbl_tag", 64'(req_tag), 64'(vecs[i].e.tag));
      chk("tbl_index", 64'(req_index), 64'(vecs[i].e.idx));
      chk("tbl_offset", 64'(req_offset), 64'(vecs[i].e.off));
      req_ready = 1'b1;
      wait_q_empty();
      tick();
      req_ready = 1'b0;
      chk("tbl_valid_drop", 64'(req_valid), 64'd0);
    end

    // Back-to-back requests, one per cycle.
    req_ready = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) send(4'(i), $urandom);
    wait_q_empty();
    chk("b2b_count", 64'(hs_cyc.size()), 64'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("b2b_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
    tick();

    // Backpressure: five records into a four-deep FIFO.
    req_ready = 1'b0;
    hs_cyc.delete();
    send(4'd0, $urandom);
    send(4'd1, $urandom);
    send(4'd5, $urandom);
    send(4'd6, $urandom);
    send(4'd2, $urandom);
    chk("bp_full", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(req_valid), 64'd1);
    chk("bp_head_op", 64'(req_op), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    req_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_during_pop", 64'(in_ready), 64'd0);
    wait_q_empty();
    chk("bp_count", 64'(hs_cyc.size()), 64'd5);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("bp_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
    tick();
    tick();
    chk("bp_idle_busy", 64'(busy), 64'd0);

    // Print then snoop read.
    send(4'd9, 32'd0);
    send(4'd4, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("pr_hold", 64'(print_req), 64'd1);
      chk("pr_no_req", 64'(req_valid), 64'd0);
      tick();
    end
    print_done = 1'b1;
    tick();
    print_done = 1'b0;
    chk("pr_drop", 64'(print_req), 64'd0);
    chk("pr_drop_no_req", 64'(req_valid), 64'd0);
    tick();
    chk("pr_then_req", 64'(req_valid), 64'd1);
    chk("pr_then_op", 64'(req_op), 64'd4);
    wait_q_empty();
    tick();

    // Clear then two illegal codes.
    n_clear = 0;
    n_err = 0;
    send(4'd8, 32'd0);
    send(4'd7, 32'd0);
    send(4'd15, 32'd0);
    repeat (5) tick();
    chk("clr_count", 64'(n_clear), 64'd1);
    chk("err_count", 64'(n_err), 64'd2);
    chk("clr_idle", 64'(busy), 64'd0);
    chk_stats();

    // Reset with a request held and three records queued.
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd1, $urandom);
    chk("mr_valid", 64'(req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid_drop", 64'(req_valid), 64'd0);
    chk("mr_busy_drop", 64'(busy), 64'd0);
    exp_q.delete();
    m_reads = 0; m_writes = 0; m_fetches = 0; m_snoops = 0; m_illegal = 0;
    tick();
    rst_n = 1'b1;
    req_ready = 1'b1;
    n_hs = 0;
    repeat (10) tick();
    chk("mr_no_stale", 64'(n_hs), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk_stats();

    // Fresh request after reset still works.
    send(4'd2, 32'h0BAD_F00D);
    wait_q_empty();
    tick();
    chk("final_hs", 64'(n_hs), 64'd1);
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_cmd_dispatch.md
Name: trace_cmd_dispatch

Overview:
- Clocked stage directly downstream of the trace-file reader.
- Accepts parsed trace records (command code plus address) over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each record in order:
  - codes 0-6 become cache requests, with the address split into tag/index/offset, issued to the L2 controller;
  - code 8 becomes a one-cycle clear pulse;
  - code 9 becomes a print request/done handshake;
  - all other codes are dropped and flagged.

Parameters:
- ADDR_W, 32, trace address width.
- OFFSET_W, 6, line offset bits (64-byte lines).
- INDEX_W, 14, set index bits; tag width = ADDR_W-INDEX_W-OFFSET_W.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  trace record valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_cmd  in  4  trace command code.
- in_addr  in  ADDR_W  trace address.
- req_valid  out  1  cache request valid.
- req_ready  in  1  L2 controller accepts request.
- req_op  out  3  l2_op_e: 0=DR 1=DW 2=IR 3=SI 4=SR 5=SW 6=SM.
- req_tag  out  ADDR_W-INDEX_W-OFFSET_W  address tag.
- req_index  out  INDEX_W  set index.
- req_offset  out  OFFSET_W  byte offset.
- clear_pulse  out  1  one-cycle cache clear/reset.
- print_req  out  1  request cache content dump.
- print_done  in  1  dump complete.
- err_illegal  out  1  one-cycle pulse on dropped code.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; pending entries are discarded.
  - FSM enters IDLE.
  - req_valid, clear_pulse, print_req, err_illegal, busy are 0; req_op/tag/index/offset are 0; stat counters are 0.
  - This applies identically mid-transaction: a held req_valid or print_req drops immediately.
- FIFO:
  - Push on in_valid&&in_ready. Pop only by the FSM.
  - When full, in_ready=0 even if a pop occurs in the same cycle; there is no pass-through.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Output registers: all outputs are registered. Record order is strictly preserved.
- FSM states: IDLE, ISSUE, PRINT_WAIT.
  - IDLE, FIFO empty: hold.
  - IDLE, head code 0-6: load op/tag/index/offset, set req_valid, pop, go ISSUE.
  - IDLE, head code 8: clear_pulse=1 for one cycle, pop, stay IDLE.
  - IDLE, head code 9: set print_req, pop, go PRINT_WAIT.
  - IDLE, head code 7 or 10-15: err_illegal=1 for one cycle, pop, stay IDLE.
  - ISSUE: hold req_valid and payload stable until req_ready.
    - On handshake with head code 0-6: load next request and pop the same cycle (back-to-back, one request per cycle).
    - On handshake otherwise: req_valid<=0, go IDLE.
  - PRINT_WAIT: hold print_req=1 until print_done sampled high, then print_req<=0 and go IDLE.
  - print_done outside PRINT_WAIT is ignored.
- Latency:
  - A record pushed at edge N into an empty FIFO appears as req_valid after edge N+1.
  - Codes 8/9/illegal following a request are processed no earlier than the cycle after that request's handshake.
- Address split: offset=in_addr[OFFSET_W-1:0], index=next INDEX_W bits, tag=remaining MSBs. No arithmetic.

Optional Feature:
- Macro TRACE_DISPATCH_STATS_EN.
- Defined:
  - Output ports stat_reads, stat_writes, stat_fetches, stat_snoops, stat_illegal (CNT_W each) are added.
  - Reads count DR; writes count DW; fetches count IR; snoops count codes 3-6; illegal counts dropped codes.
  - Counters increment on request handshake (or on drop, for illegal) and saturate at all-ones.
  - Counters are unaffected by code 8; only rst_n clears them.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package l2_trace_pkg:
  - l2_op_e enum;
  - trace command constants CMD_DR..CMD_SM, CMD_CLEAR=8, CMD_PRINT=9;
  - dispatch_state_e.
- Sub-module trace_cmd_fifo: parameterised synchronous FIFO with push/pop/full/empty/head outputs, instantiated once.

Test Plan:
- Reset with in_valid=1 → in_ready=1, all outputs 0. Push {0, 0x1234_5678} → after next edge: req_op=0, tag=0x123, index=0x1159, offset=0x38.
- req_ready=1, push codes 0,1,2,3 on consecutive cycles → four requests on four consecutive cycles, ops 0,1,2,3, in order.
- req_ready=0, push 5 records into DEPTH=4 → first record is loaded to the output and 4 remain queued. in_ready drops after the FIFO fills and stays 0 while full, including during a pop. Release req_ready → all 5 issued in order, no loss or duplication.
- Push 9 then 4 → print_req held high, no req_valid. Assert print_done 3 cycles later → print_req drops, then a snoop-read request is issued.
- Push 8, 7, 15 → one clear_pulse cycle, then two err_illegal pulses. With TRACE_DISPATCH_STATS_EN: stat_illegal=2.
- Assert rst_n=0 while req_valid=1 and FIFO holds 3 records → outputs clear immediately and busy=0 after release. A pre-reset record is never issued.
